// File: rtl/yazmac_oku_asamasi_pkg.sv
// Shared RV32I decode constants for the register-read and execute stages.
package yazmac_oku_asamasi_pkg;

  // Base opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Field positions (least significant bit of each field)
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

endpackage

// File: rtl/yazmac_oku_asamasi_yonlendirme_birimi.sv
// Per-operand forwarding mux: x0 forced to zero, then EX > MEM > WB > register file.
module yonlendirme_birimi #(
  parameter int XLEN  = 32,
  parameter int ADR_W = 5
) (
  input  logic [ADR_W-1:0] i_adr,
  input  logic             i_yur_yaz,
  input  logic             i_yur_yukle,
  input  logic [ADR_W-1:0] i_yur_adr,
  input  logic [XLEN-1:0]  i_yur_deger,
  input  logic             i_bel_yaz,
  input  logic [ADR_W-1:0] i_bel_adr,
  input  logic [XLEN-1:0]  i_bel_deger,
  input  logic             i_gy_yaz,
  input  logic [ADR_W-1:0] i_gy_adr,
  input  logic [XLEN-1:0]  i_gy_deger,
  input  logic [XLEN-1:0]  i_rf_deger,
  output logic [XLEN-1:0]  o_deger
);

  // Select the youngest producer of the operand; a load in EX has no data yet
  always_comb begin
    o_deger = i_rf_deger;
    if (i_adr == '0) begin
      o_deger = '0;
    end else if (i_yur_yaz && !i_yur_yukle && (i_yur_adr == i_adr)) begin
      o_deger = i_yur_deger;
    end else if (i_bel_yaz && (i_bel_adr == i_adr)) begin
      o_deger = i_bel_deger;
    end else if (i_gy_yaz && (i_gy_adr == i_adr)) begin
      o_deger = i_gy_deger;
    end
  end

endmodule

// File: rtl/yazmac_oku_asamasi.sv
// Decode / register-read stage: operand resolution, load-use stall, output register.
module yazmac_oku_asamasi
  import yazmac_oku_asamasi_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ADR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  buyruk_i,
  input  logic [XLEN-1:0]  ps_i,
  input  logic             gecerli_i,
  output logic             hazir_o,
  output logic [ADR_W-1:0] oku1_adr_o,
  output logic [ADR_W-1:0] oku2_adr_o,
  input  logic [XLEN-1:0]  oku1_deger_i,
  input  logic [XLEN-1:0]  oku2_deger_i,
  input  logic             yur_yaz_i,
  input  logic             yur_yukle_i,
  input  logic [ADR_W-1:0] yur_adr_i,
  input  logic [XLEN-1:0]  yur_deger_i,
  input  logic             bel_yaz_i,
  input  logic [ADR_W-1:0] bel_adr_i,
  input  logic [XLEN-1:0]  bel_deger_i,
  input  logic             gy_yaz_i,
  input  logic [ADR_W-1:0] gy_adr_i,
  input  logic [XLEN-1:0]  gy_deger_i,
  input  logic             temizle_i,
  output logic [XLEN-1:0]  rs1_deger_o,
  output logic [XLEN-1:0]  rs2_deger_o,
  output logic [ADR_W-1:0] hy_adr_o,
  output logic             hy_yaz_o,
  output logic [XLEN-1:0]  buyruk_o,
  output logic [XLEN-1:0]  ps_o,
  output logic             gecerli_o,
  input  logic             hazir_i,
  output logic [31:0]      durdurma_sayac_o
);

  logic [OPC_W-1:0] w_opc;
  logic [ADR_W-1:0] w_rs1;
  logic [ADR_W-1:0] w_rs2;
  logic [ADR_W-1:0] w_rd;
  logic             w_kullan1;
  logic             w_kullan2;
  logic             w_yaz_hy;
  logic             w_durdur;
  logic             w_ilerle;
  logic [XLEN-1:0]  w_rs1_deger;
  logic [XLEN-1:0]  w_rs2_deger;

  logic [XLEN-1:0]  r_rs1_deger_p0;
  logic [XLEN-1:0]  r_rs2_deger_p0;
  logic [ADR_W-1:0] r_hy_adr_p0;
  logic             r_hy_yaz_p0;
  logic [XLEN-1:0]  r_buyruk_p0;
  logic [XLEN-1:0]  r_ps_p0;
  logic             r_vld_p0;
  logic [31:0]      r_durdurma_sayac;

  assign w_opc = buyruk_i[OPC_LSB +: OPC_W];
  assign w_rs1 = buyruk_i[RS1_LSB +: ADR_W];
  assign w_rs2 = buyruk_i[RS2_LSB +: ADR_W];
  assign w_rd  = buyruk_i[RD_LSB  +: ADR_W];

  // Register file is addressed straight from the raw instruction, valid or not
  assign oku1_adr_o = w_rs1;
  assign oku2_adr_o = w_rs2;

  // Which source registers the instruction really reads, and whether it writes rd
  always_comb begin
    w_kullan1 = !((w_opc == OPC_LUI) || (w_opc == OPC_AUIPC) || (w_opc == OPC_JAL));
    w_kullan2 = (w_opc == OPC_OP) || (w_opc == OPC_STORE) || (w_opc == OPC_BRANCH);
    w_yaz_hy  = !((w_opc == OPC_STORE) || (w_opc == OPC_BRANCH)) && (w_rd != '0);
  end

  // Load in EX whose rd is a live source of this instruction: wait one cycle
  always_comb begin
    w_durdur = gecerli_i && yur_yaz_i && yur_yukle_i && (yur_adr_i != '0) &&
               ((w_kullan1 && (yur_adr_i == w_rs1)) ||
                (w_kullan2 && (yur_adr_i == w_rs2)));
  end

  assign w_ilerle = !r_vld_p0 || hazir_i;
  // A flush always drains the upstream instruction so fetch can redirect
  assign hazir_o  = temizle_i || (w_ilerle && !w_durdur);

  yonlendirme_birimi #(.XLEN(XLEN), .ADR_W(ADR_W)) u_yonlendirme1 (
    .i_adr       (w_rs1),
    .i_yur_yaz   (yur_yaz_i),
    .i_yur_yukle (yur_yukle_i),
    .i_yur_adr   (yur_adr_i),
    .i_yur_deger (yur_deger_i),
    .i_bel_yaz   (bel_yaz_i),
    .i_bel_adr   (bel_adr_i),
    .i_bel_deger (bel_deger_i),
    .i_gy_yaz    (gy_yaz_i),
    .i_gy_adr    (gy_adr_i),
    .i_gy_deger  (gy_deger_i),
    .i_rf_deger  (oku1_deger_i),
    .o_deger     (w_rs1_deger)
  );

  yonlendirme_birimi #(.XLEN(XLEN), .ADR_W(ADR_W)) u_yonlendirme2 (
    .i_adr       (w_rs2),
    .i_yur_yaz   (yur_yaz_i),
    .i_yur_yukle (yur_yukle_i),
    .i_yur_adr   (yur_adr_i),
    .i_yur_deger (yur_deger_i),
    .i_bel_yaz   (bel_yaz_i),
    .i_bel_adr   (bel_adr_i),
    .i_bel_deger (bel_deger_i),
    .i_gy_yaz    (gy_yaz_i),
    .i_gy_adr    (gy_adr_i),
    .i_gy_deger  (gy_deger_i),
    .i_rf_deger  (oku2_deger_i),
    .o_deger     (w_rs2_deger)
  );

  // ---- stage p0: register toward execute ----
  // Output register: flush kills, stall inserts a bubble, downstream backpressure holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1_deger_p0 <= '0;
      r_rs2_deger_p0 <= '0;
      r_hy_adr_p0    <= '0;
      r_hy_yaz_p0    <= 1'b0;
      r_buyruk_p0    <= '0;
      r_ps_p0        <= '0;
      r_vld_p0       <= 1'b0;
    end else if (temizle_i) begin
      r_vld_p0    <= 1'b0;
      r_hy_yaz_p0 <= 1'b0;
    end else if (w_ilerle) begin
      if (gecerli_i && !w_durdur) begin
        r_rs1_deger_p0 <= w_rs1_deger;
        r_rs2_deger_p0 <= w_rs2_deger;
        r_hy_adr_p0    <= w_rd;
        r_hy_yaz_p0    <= w_yaz_hy;
        r_buyruk_p0    <= buyruk_i;
        r_ps_p0        <= ps_i;
        r_vld_p0       <= 1'b1;
      end else begin
        r_vld_p0    <= 1'b0;
        r_hy_yaz_p0 <= 1'b0;
      end
    end
  end

  // Count only stall cycles that actually produced a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_durdurma_sayac <= '0;
    end else if (w_durdur && w_ilerle && !temizle_i) begin
      r_durdurma_sayac <= r_durdurma_sayac + 32'd1;
    end
  end

  assign rs1_deger_o      = r_rs1_deger_p0;
  assign rs2_deger_o      = r_rs2_deger_p0;
  assign hy_adr_o         = r_hy_adr_p0;
  assign hy_yaz_o         = r_hy_yaz_p0;
  assign buyruk_o         = r_buyruk_p0;
  assign ps_o             = r_ps_p0;
  assign gecerli_o        = r_vld_p0;
  assign durdurma_sayac_o = r_durdurma_sayac;

endmodule

// File: tb/tb_yazmac_oku_asamasi.sv
// Self-checking bench for the register-read stage with an output scoreboard.
module tb_yazmac_oku_asamasi;

  localparam int XLEN  = 32;
  localparam int ADR_W = 5;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_ADD4  = 32'h00208233; // add x4,x1,x2
  localparam logic [31:0] I_ADDX0 = 32'h002001B3; // add x3,x0,x2
  localparam logic [31:0] I_RD0   = 32'h00208033; // add x0,x1,x2
  localparam logic [31:0] I_SW    = 32'h0050A423; // sw x5,8(x1)
  localparam logic [31:0] I_SW1   = 32'h00112023; // sw x1,0(x2)
  localparam logic [31:0] I_LUI   = 32'h000081B7; // lui x3 with rs1 field = 1
  localparam logic [31:0] I_ADDI  = 32'h00110193; // addi x3,x2,1 (rs2 field = 1)

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  buyruk_i, ps_i;
  logic             gecerli_i, hazir_o;
  logic [ADR_W-1:0] oku1_adr_o, oku2_adr_o;
  logic [XLEN-1:0]  oku1_deger_i, oku2_deger_i;
  logic             yur_yaz_i, yur_yukle_i;
  logic [ADR_W-1:0] yur_adr_i;
  logic [XLEN-1:0]  yur_deger_i;
  logic             bel_yaz_i;
  logic [ADR_W-1:0] bel_adr_i;
  logic [XLEN-1:0]  bel_deger_i;
  logic             gy_yaz_i;
  logic [ADR_W-1:0] gy_adr_i;
  logic [XLEN-1:0]  gy_deger_i;
  logic             temizle_i;
  logic [XLEN-1:0]  rs1_deger_o, rs2_deger_o;
  logic [ADR_W-1:0] hy_adr_o;
  logic             hy_yaz_o;
  logic [XLEN-1:0]  buyruk_o, ps_o;
  logic             gecerli_o, hazir_i;
  logic [31:0]      durdurma_sayac_o;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  adr;
    logic        yaz;
    logic [31:0] buyruk;
    logic [31:0] ps;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_a, mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  assign oku1_deger_i = rf[oku1_adr_o];
  assign oku2_deger_i = rf[oku2_adr_o];

  yazmac_oku_asamasi #(.XLEN(XLEN), .ADR_W(ADR_W)) dut (
    .clk(clk), .rst(rst),
    .buyruk_i(buyruk_i), .ps_i(ps_i), .gecerli_i(gecerli_i), .hazir_o(hazir_o),
    .oku1_adr_o(oku1_adr_o), .oku2_adr_o(oku2_adr_o),
    .oku1_deger_i(oku1_deger_i), .oku2_deger_i(oku2_deger_i),
    .yur_yaz_i(yur_yaz_i), .yur_yukle_i(yur_yukle_i), .yur_adr_i(yur_adr_i), .yur_deger_i(yur_deger_i),
    .bel_yaz_i(bel_yaz_i), .bel_adr_i(bel_adr_i), .bel_deger_i(bel_deger_i),
    .gy_yaz_i(gy_yaz_i), .gy_adr_i(gy_adr_i), .gy_deger_i(gy_deger_i),
    .temizle_i(temizle_i),
    .rs1_deger_o(rs1_deger_o), .rs2_deger_o(rs2_deger_o),
    .hy_adr_o(hy_adr_o), .hy_yaz_o(hy_yaz_o),
    .buyruk_o(buyruk_o), .ps_o(ps_o),
    .gecerli_o(gecerli_o), .hazir_i(hazir_i),
    .durdurma_sayac_o(durdurma_sayac_o)
  );

  // Scoreboard: every downstream transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (rst === 1'b0 && gecerli_o === 1'b1 && hazir_i === 1'b1) begin
      mon_a = '{rs1: rs1_deger_o, rs2: rs2_deger_o, adr: hy_adr_o, yaz: hy_yaz_o,
                buyruk: buyruk_o, ps: ps_o};
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected got=%h expected=<none>", mon_a);
      end else begin
        mon_e = q.pop_front();
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL scoreboard got rs1=%h rs2=%h adr=%0d yaz=%b buyruk=%h ps=%h expected rs1=%h rs2=%h adr=%0d yaz=%b buyruk=%h ps=%h",
                   mon_a.rs1, mon_a.rs2, mon_a.adr, mon_a.yaz, mon_a.buyruk, mon_a.ps,
                   mon_e.rs1, mon_e.rs2, mon_e.adr, mon_e.yaz, mon_e.buyruk, mon_e.ps);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    gecerli_i   = 1'b0;
    buyruk_i    = 32'h00000013;
    ps_i        = '0;
    yur_yaz_i   = 1'b0;
    yur_yukle_i = 1'b0;
    yur_adr_i   = '0;
    yur_deger_i = '0;
    bel_yaz_i   = 1'b0;
    bel_adr_i   = '0;
    bel_deger_i = '0;
    gy_yaz_i    = 1'b0;
    gy_adr_i    = '0;
    gy_deger_i  = '0;
    temizle_i   = 1'b0;
  endtask

  // Independent priority model of one operand
  function automatic logic [31:0] model_fwd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (yur_yaz_i && !yur_yukle_i && yur_adr_i == a) return yur_deger_i;
    if (bel_yaz_i && bel_adr_i == a) return bel_deger_i;
    if (gy_yaz_i && gy_adr_i == a) return gy_deger_i;
    return rf[a];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    hazir_i = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 32'd0;
    n_chk++; if (gecerli_o !== 1'b0) begin n_fail++; $display("FAIL reset_gecerli got=%b expected=0", gecerli_o); end
    n_chk++; if (rs1_deger_o !== 32'd0) begin n_fail++; $display("FAIL reset_rs1 got=%h expected=0", rs1_deger_o); end
    n_chk++; if (rs2_deger_o !== 32'd0) begin n_fail++; $display("FAIL reset_rs2 got=%h expected=0", rs2_deger_o); end
    n_chk++; if (hy_adr_o !== 5'd0) begin n_fail++; $display("FAIL reset_hy_adr got=%0d expected=0", hy_adr_o); end
    n_chk++; if (hy_yaz_o !== 1'b0) begin n_fail++; $display("FAIL reset_hy_yaz got=%b expected=0", hy_yaz_o); end
    n_chk++; if (buyruk_o !== 32'd0) begin n_fail++; $display("FAIL reset_buyruk got=%h expected=0", buyruk_o); end
    n_chk++; if (ps_o !== 32'd0) begin n_fail++; $display("FAIL reset_ps got=%h expected=0", ps_o); end
    n_chk++; if (durdurma_sayac_o !== 32'd0) begin n_fail++; $display("FAIL reset_sayac got=%h expected=0", durdurma_sayac_o); end
    #1;
    n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL reset_hazir got=%b expected=1", hazir_o); end
  endtask

  task automatic test_add();
    idle();
    buyruk_i = I_ADD; ps_i = 32'h100; gecerli_i = 1'b1;
    #1;
    n_chk++; if (oku1_adr_o !== 5'd1 || oku2_adr_o !== 5'd2) begin n_fail++; $display("FAIL add_oku_adr got=%0d,%0d expected=1,2", oku1_adr_o, oku2_adr_o); end
    n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL add_hazir got=%b expected=1", hazir_o); end
    q.push_back('{rs1: 32'd5, rs2: 32'd7, adr: 5'd3, yaz: 1'b1, buyruk: I_ADD, ps: 32'h100});
    tick();
    n_chk++; if (gecerli_o !== 1'b1) begin n_fail++; $display("FAIL add_gecerli got=%b expected=1", gecerli_o); end
    idle();
    tick();
    n_chk++; if (gecerli_o !== 1'b0) begin n_fail++; $display("FAIL add_idle_gecerli got=%b expected=0", gecerli_o); end
  endtask

  task automatic test_forward();
    idle();
    buyruk_i = I_ADD; ps_i = 32'h104; gecerli_i = 1'b1;
    yur_yaz_i = 1'b1; yur_adr_i = 5'd1; yur_deger_i = 32'hAA;
    bel_yaz_i = 1'b1; bel_adr_i = 5'd1; bel_deger_i = 32'hBB;
    gy_yaz_i  = 1'b1; gy_adr_i  = 5'd2; gy_deger_i  = 32'hCC;
    q.push_back('{rs1: 32'hAA, rs2: 32'hCC, adr: 5'd3, yaz: 1'b1, buyruk: I_ADD, ps: 32'h104});
    tick();
    // MEM now outranks WB for x2 when EX is silent
    yur_yaz_i = 1'b0; bel_adr_i = 5'd2; ps_i = 32'h108;
    q.push_back('{rs1: 32'd5, rs2: 32'hBB, adr: 5'd3, yaz: 1'b1, buyruk: I_ADD, ps: 32'h108});
    tick();
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    buyruk_i = I_ADD; ps_i = 32'h10C; gecerli_i = 1'b1;
    yur_yaz_i = 1'b1; yur_yukle_i = 1'b1; yur_adr_i = 5'd1; yur_deger_i = 32'hDEAD;
    #1;
    n_chk++; if (hazir_o !== 1'b0) begin n_fail++; $display("FAIL loaduse_hazir got=%b expected=0", hazir_o); end
    tick();
    exp_cnt = exp_cnt + 32'd1;
    n_chk++; if (gecerli_o !== 1'b0 || hy_yaz_o !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble got=%b/%b expected=0/0", gecerli_o, hy_yaz_o); end
    n_chk++; if (durdurma_sayac_o !== exp_cnt) begin n_fail++; $display("FAIL loaduse_sayac got=%0d expected=%0d", durdurma_sayac_o, exp_cnt); end
    yur_yaz_i = 1'b0; yur_yukle_i = 1'b0;
    bel_yaz_i = 1'b1; bel_adr_i = 5'd1; bel_deger_i = 32'h55;
    #1;
    n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL loaduse_release got=%b expected=1", hazir_o); end
    q.push_back('{rs1: 32'h55, rs2: 32'd7, adr: 5'd3, yaz: 1'b1, buyruk: I_ADD, ps: 32'h10C});
    tick();
    n_chk++; if (gecerli_o !== 1'b1) begin n_fail++; $display("FAIL loaduse_gecerli got=%b expected=1", gecerli_o); end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    buyruk_i = I_ADD; ps_i = 32'h110; gecerli_i = 1'b1;
    q.push_back('{rs1: 32'd5, rs2: 32'd7, adr: 5'd3, yaz: 1'b1, buyruk: I_ADD, ps: 32'h110});
    tick();
    hazir_i = 1'b0;
    buyruk_i = I_ADD4; ps_i = 32'h114;
    yur_yaz_i = 1'b1; yur_yukle_i = 1'b1; yur_adr_i = 5'd1;
    #1;
    n_chk++; if (hazir_o !== 1'b0) begin n_fail++; $display("FAIL bp_hazir got=%b expected=0", hazir_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (gecerli_o !== 1'b1 || buyruk_o !== I_ADD || rs1_deger_o !== 32'd5 || ps_o !== 32'h110)
        begin n_fail++; $display("FAIL bp_hold%0d got=%b %h %h %h expected=1 %h 5 110", i, gecerli_o, buyruk_o, rs1_deger_o, ps_o, I_ADD); end
      n_chk++; if (durdurma_sayac_o !== exp_cnt) begin n_fail++; $display("FAIL bp_sayac%0d got=%0d expected=%0d", i, durdurma_sayac_o, exp_cnt); end
      n_chk++; if (hazir_o !== 1'b0) begin n_fail++; $display("FAIL bp_hazir%0d got=%b expected=0", i, hazir_o); end
    end
    yur_yaz_i = 1'b0; yur_yukle_i = 1'b0;
    hazir_i = 1'b1;
    q.push_back('{rs1: 32'd5, rs2: 32'd7, adr: 5'd4, yaz: 1'b1, buyruk: I_ADD4, ps: 32'h114});
    #1;
    n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b expected=1", hazir_o); end
    tick();
    n_chk++; if (buyruk_o !== I_ADD4) begin n_fail++; $display("FAIL bp_next got=%h expected=%h", buyruk_o, I_ADD4); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    buyruk_i = I_ADD; ps_i = 32'h118; gecerli_i = 1'b1;
    yur_yaz_i = 1'b1; yur_yukle_i = 1'b1; yur_adr_i = 5'd2;
    tick();
    exp_cnt = exp_cnt + 32'd1;
    n_chk++; if (durdurma_sayac_o !== exp_cnt) begin n_fail++; $display("FAIL flush_pre_sayac got=%0d expected=%0d", durdurma_sayac_o, exp_cnt); end
    temizle_i = 1'b1;
    #1;
    n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL flush_hazir got=%b expected=1", hazir_o); end
    tick();
    n_chk++; if (gecerli_o !== 1'b0 || hy_yaz_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b/%b expected=0/0", gecerli_o, hy_yaz_o); end
    n_chk++; if (durdurma_sayac_o !== exp_cnt) begin n_fail++; $display("FAIL flush_sayac got=%0d expected=%0d", durdurma_sayac_o, exp_cnt); end
    // Flush also kills a valid result held by downstream backpressure
    idle();
    buyruk_i = I_ADD; ps_i = 32'h11C; gecerli_i = 1'b1;
    tick();
    hazir_i = 1'b0;
    gecerli_i = 1'b0;
    temizle_i = 1'b1;
    tick();
    n_chk++; if (gecerli_o !== 1'b0 || hy_yaz_o !== 1'b0) begin n_fail++; $display("FAIL flush_held got=%b/%b expected=0/0", gecerli_o, hy_yaz_o); end
    hazir_i = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_x0();
    idle();
    rf[0] = 32'h1234;
    rf[5] = 32'h50;
    buyruk_i = I_ADDX0; ps_i = 32'h120; gecerli_i = 1'b1;
    yur_yaz_i = 1'b1; yur_adr_i = 5'd0; yur_deger_i = 32'hDEAD;
    q.push_back('{rs1: 32'd0, rs2: 32'd7, adr: 5'd3, yaz: 1'b1, buyruk: I_ADDX0, ps: 32'h120});
    tick();
    yur_yaz_i = 1'b0;
    buyruk_i = I_RD0; ps_i = 32'h124;
    q.push_back('{rs1: 32'd5, rs2: 32'd7, adr: 5'd0, yaz: 1'b0, buyruk: I_RD0, ps: 32'h124});
    tick();
    buyruk_i = I_SW; ps_i = 32'h128;
    q.push_back('{rs1: 32'd5, rs2: 32'h50, adr: 5'd8, yaz: 1'b0, buyruk: I_SW, ps: 32'h128});
    tick();
    // A load targeting x0 never stalls
    buyruk_i = I_ADDX0; ps_i = 32'h12C;
    yur_yaz_i = 1'b1; yur_yukle_i = 1'b1; yur_adr_i = 5'd0;
    #1;
    n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL x0_load_hazir got=%b expected=1", hazir_o); end
    q.push_back('{rs1: 32'd0, rs2: 32'd7, adr: 5'd3, yaz: 1'b1, buyruk: I_ADDX0, ps: 32'h12C});
    tick();
    idle();
    rf[0] = 32'd0;
    tick();
  endtask

  task automatic test_kullan();
    idle();
    yur_yaz_i = 1'b1; yur_yukle_i = 1'b1; yur_adr_i = 5'd1;
    buyruk_i = I_LUI; ps_i = 32'h130; gecerli_i = 1'b1;
    #1;
    n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL kullan_lui_hazir got=%b expected=1", hazir_o); end
    q.push_back('{rs1: 32'd5, rs2: 32'd0, adr: 5'd3, yaz: 1'b1, buyruk: I_LUI, ps: 32'h130});
    tick();
    buyruk_i = I_ADDI; ps_i = 32'h134;
    #1;
    n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL kullan_addi_hazir got=%b expected=1", hazir_o); end
    q.push_back('{rs1: 32'd7, rs2: 32'd5, adr: 5'd3, yaz: 1'b1, buyruk: I_ADDI, ps: 32'h134});
    tick();
    buyruk_i = I_SW1; ps_i = 32'h138;
    #1;
    n_chk++; if (hazir_o !== 1'b0) begin n_fail++; $display("FAIL kullan_store_hazir got=%b expected=0", hazir_o); end
    tick();
    exp_cnt = exp_cnt + 32'd1;
    n_chk++; if (durdurma_sayac_o !== exp_cnt) begin n_fail++; $display("FAIL kullan_store_sayac got=%0d expected=%0d", durdurma_sayac_o, exp_cnt); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  r1, r2, rd;
    logic [31:0] ins;
    idle();
    for (int i = 0; i < 24; i++) begin
      r1 = 5'($urandom_range(0, 4));
      r2 = 5'($urandom_range(0, 4));
      rd = 5'($urandom_range(0, 31));
      rf[r1] = $urandom();
      rf[r2] = $urandom();
      rf[0]  = $urandom();
      ins = {7'b0, r2, r1, 3'b000, rd, 7'b0110011};
      buyruk_i = ins; ps_i = 32'h200 + 32'(i * 4); gecerli_i = 1'b1;
      yur_yaz_i = 1'($urandom_range(0, 1)); yur_adr_i = 5'($urandom_range(0, 4)); yur_deger_i = $urandom();
      bel_yaz_i = 1'($urandom_range(0, 1)); bel_adr_i = 5'($urandom_range(0, 4)); bel_deger_i = $urandom();
      gy_yaz_i  = 1'($urandom_range(0, 1)); gy_adr_i  = 5'($urandom_range(0, 4)); gy_deger_i  = $urandom();
      q.push_back('{rs1: model_fwd(r1), rs2: model_fwd(r2), adr: rd, yaz: (rd != 5'd0),
                    buyruk: ins, ps: 32'h200 + 32'(i * 4)});
      #1;
      n_chk++; if (hazir_o !== 1'b1) begin n_fail++; $display("FAIL b2b_hazir%0d got=%b expected=1", i, hazir_o); end
      tick();
    end
    idle();
    rf[0] = 32'd0;
    tick();
    tick();
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL b2b_drain got=%0d pending expected=0", q.size()); end
    n_chk++; if (durdurma_sayac_o !== exp_cnt) begin n_fail++; $display("FAIL b2b_sayac got=%0d expected=%0d", durdurma_sayac_o, exp_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_x0();
    test_kullan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/yazmac_oku_asamasi.md
Name: yazmac_oku_asamasi

Overview:
- Decode/register-read pipeline stage between fetch and execute in the RV32I core.
- Extracts rs1/rs2/rd from the incoming instruction and drives the register file's combinational read ports.
- Resolves operand values with EX/MEM/WB forwarding and stalls on load-use hazards.
- Registers the result into a valid/ready pipeline register toward execute, and counts stall cycles for performance monitoring.

Parameters:
- XLEN, 32, data width of operands, PC and instruction.
- ADR_W, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- buyruk_i  in  XLEN  instruction from fetch
- ps_i  in  XLEN  PC of buyruk_i
- gecerli_i  in  1  upstream valid
- hazir_o  out  1  ready to upstream
- oku1_adr_o  out  ADR_W  register file rs1 address
- oku2_adr_o  out  ADR_W  register file rs2 address
- oku1_deger_i  in  XLEN  register file rs1 data (combinational)
- oku2_deger_i  in  XLEN  register file rs2 data (combinational)
- yur_yaz_i, yur_yukle_i  in  1 each  EX stage writes rd / EX instruction is a load
- yur_adr_i  in  ADR_W  EX rd;  yur_deger_i  in  XLEN  EX result
- bel_yaz_i  in  1;  bel_adr_i  in  ADR_W;  bel_deger_i  in  XLEN  MEM stage write-back info
- gy_yaz_i  in  1;  gy_adr_i  in  ADR_W;  gy_deger_i  in  XLEN  WB stage write, same signals as the register file write port
- temizle_i  in  1  flush (branch/jump redirect)
- rs1_deger_o, rs2_deger_o  out  XLEN  resolved operands
- hy_adr_o  out  ADR_W  destination register
- hy_yaz_o  out  1  destination write enable
- buyruk_o, ps_o  out  XLEN  registered instruction and PC
- gecerli_o  out  1  downstream valid
- hazir_i  in  1  downstream ready
- durdurma_sayac_o  out  32  load-use stall cycle counter

Behaviour:
- Reset: gecerli_o=0; rs1/rs2_deger_o, hy_adr_o, hy_yaz_o, buyruk_o, ps_o, durdurma_sayac_o all 0. Reset applies synchronously on posedge clk.
- Priority at each posedge: rst > temizle_i > normal operation.
- Address decode is combinational from buyruk_i:
  - rs1=[19:15], rs2=[24:20], rd=[11:7].
  - oku1_adr_o and oku2_adr_o follow buyruk_i every cycle, regardless of gecerli_i.
- Register usage by opcode:
  - kullan1 is 0 for LUI, AUIPC and JAL; 1 otherwise.
  - kullan2 is 1 for R-type, STORE and BRANCH only.
  - yaz_hy is 0 for STORE, BRANCH and rd==0; 1 otherwise.
- Forwarding, per operand, highest priority first:
  1. Address 0 -> value 0.
  2. EX (yur_yaz_i && yur_adr_i==adr && !yur_yukle_i) -> yur_deger_i.
  3. MEM (bel_yaz_i && bel_adr_i==adr) -> bel_deger_i.
  4. WB (gy_yaz_i && gy_adr_i==adr) -> gy_deger_i.
  5. Otherwise -> register file data.
- Load-use stall:
  - durdur = gecerli_i && yur_yaz_i && yur_yukle_i && yur_adr_i!=0, and (kullan1 && yur_adr_i==rs1, or kullan2 && yur_adr_i==rs2).
  - durdur never matches on address 0.
- Handshake:
  - ilerle = !gecerli_o || hazir_i.
  - hazir_o = ilerle && !durdur.
  - Transfer from upstream occurs when gecerli_i && hazir_o.
- On posedge, when ilerle:
  - If gecerli_i && !durdur: load the output register with resolved operands, rd, yaz_hy, buyruk_i, ps_i, and set gecerli_o=1.
  - If durdur: insert a bubble (gecerli_o=0, hy_yaz_o=0, data don't-care but held).
  - If !gecerli_i: gecerli_o=0.
- When !ilerle (downstream stalled): hold all outputs stable; forwarding is not re-evaluated.
- Flush (temizle_i=1):
  - Next cycle gecerli_o=0 and hy_yaz_o=0.
  - hazir_o=1 during flush, so the upstream instruction is consumed and dropped.
  - Counter is not incremented.
- Counter: durdurma_sayac_o increments by 1 each cycle with durdur && ilerle && !temizle_i; wraps 0xFFFFFFFF -> 0.
- Latency: 1 cycle from accepted input to gecerli_o.
- Simultaneous durdur and !hazir_i: hold (not ilerle) and do not count.

Decomposition:
- Shared package: RV32I opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM) and the field bit-position constants. The package is shared with the execute stage decoder.
- One sub-module, yonlendirme_birimi: a combinational 4-source forwarding mux with x0 handling, instantiated once per operand.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs 0, gecerli_o=0, hazir_o=1 after release with hazir_i=1.
- ADD x3,x1,x2 (0x002081B3), regfile x1=5, x2=7, no hazards -> next cycle rs1=5, rs2=7, hy_adr_o=3, hy_yaz_o=1, gecerli_o=1.
- Same ADD with EX writing x1=0xAA, MEM writing x1=0xBB, WB writing x2=0xCC -> rs1=0xAA, rs2=0xCC.
- EX load to x1 (yur_yukle_i=1), then ADD reading x1:
  - Cycle 1: hazir_o=0, bubble inserted, counter=1.
  - Following cycle: load moves to MEM, MEM forwards bel_deger_i=0x55 -> rs1=0x55.
- hazir_i=0 with gecerli_o=1 -> outputs held 3 cycles, hazir_o=0.
- Flush mid-stall: temizle_i=1 while durdur -> gecerli_o=0 next cycle, counter unchanged.
- Instruction with rd=x0, and SW x5,0(x0) -> hy_yaz_o=0 in both cases; rs1 reads x0 as 0 even with EX forwarding to address 0.
